// File: rtl/gray_pkg.sv
// Shared types and constants for the bit-serial Gray-to-binary decoder.
package gray_pkg;
  localparam int GRAY_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    DECODE,
    HOLD
  } state_t;
endpackage

// File: rtl/gray_2_binary_seq.sv
// Bit-serial Gray-to-binary decoder: accepts one word, resolves one bit per cycle
// MSB first, then holds the result until the consumer takes it.
module gray_2_binary_seq
  import gray_pkg::*;
#(
  parameter int W = GRAY_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] G,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         busy
);

  localparam int IW = $clog2(W);

  state_t         r_state;
  state_t         w_state_next;
  logic           r_in_ready;
  logic           r_out_valid;
  logic [W-1:0]   r_b;
  logic [W-1:0]   r_g;
  logic [IW-1:0]  r_idx;
  logic           w_last;

  assign w_last = (r_idx == '0);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_state_next = DECODE;
      DECODE:  if (w_last) w_state_next = HOLD;
      HOLD:    if (out_ready) w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they are clean state decodes.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_in_ready  <= (w_state_next == IDLE);
      r_out_valid <= (w_state_next == HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_b   <= '0;
      r_g   <= '0;
      r_idx <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_g   <= G;
            r_b   <= {G[W-1], {(W-1){1'b0}}};
            r_idx <= IW'(W - 2);
          end
        end
        DECODE: begin
          // Each bit depends on the bit above it, already resolved on an earlier edge.
          r_b[r_idx] <= r_b[r_idx + 1'b1] ^ r_g[r_idx];
          if (!w_last) r_idx <= r_idx - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign B         = r_b;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_gray_2_binary_seq.sv
// Directed self-checking bench for gray_2_binary_seq at W=4 and W=8.
module tb_gray_2_binary_seq;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] G;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] B;
  logic       out_valid;
  logic       out_ready;
  logic       busy;

  logic [7:0] G8;
  logic       in_valid8;
  logic       in_ready8;
  logic [7:0] B8;
  logic       out_valid8;
  logic       out_ready8;
  logic       busy8;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gray_2_binary_seq #(.W(4)) dut (
    .clk(clk), .rst(rst), .G(G), .in_valid(in_valid), .in_ready(in_ready),
    .B(B), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  gray_2_binary_seq #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .G(G8), .in_valid(in_valid8), .in_ready(in_ready8),
    .B(B8), .out_valid(out_valid8), .out_ready(out_ready8), .busy(busy8)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Push one word through the W=4 instance, scrambling G after acceptance.
  task automatic run_word(input logic [3:0] g, output logic [3:0] b, output int lat);
    G = g; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    G = ~g;
    lat = 1;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    b = B;
    tick();
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; G = 4'b1010; out_ready = 1'b1;
    in_valid8 = 1'b0; G8 = '0; out_ready8 = 1'b1;
    tick(); tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (B !== 4'b0000) begin failures++; $display("FAIL reset_B got=%b exp=0000", B); end
    checks++; if (B8 !== 8'h00) begin failures++; $display("FAIL reset_B8 got=%h exp=00", B8); end
    rst = 1'b0; in_valid = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_basic;
    G = 4'b0110; in_valid = 1'b1; out_ready = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      in_valid = 1'b0;
      if (e < 4) begin
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL basic_early_valid edge=%0d got=%b exp=0", e, out_valid); end
      end
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL basic_valid_edge4 got=%b exp=1", out_valid); end
    checks++; if (B !== 4'b0100) begin failures++; $display("FAIL basic_B got=%b exp=0100", B); end
    tick();
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL basic_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
    tick(); tick();
    checks++; if (B !== 4'b0100) begin failures++; $display("FAIL basic_retain_B got=%b exp=0100", B); end
    $display("test_basic G=0110 B=%b", B);
  endtask

  task automatic test_all_codes;
    logic [3:0] gtab [16] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100,
                              4'b1100, 4'b1101, 4'b1111, 4'b1110, 4'b1010, 4'b1011, 4'b1001, 4'b1000};
    logic [3:0] b;
    logic [3:0] expb;
    int lat;
    for (int i = 0; i < 16; i++) begin
      run_word(gtab[i], b, lat);
      expb = 4'(i);
      checks++; if (b !== expb) begin failures++; $display("FAIL codes_B G=%b got=%b exp=%b", gtab[i], b, expb); end
      checks++; if (lat != 4) begin failures++; $display("FAIL codes_latency G=%b got=%0d exp=4", gtab[i], lat); end
      checks++; if ((b ^ (b >> 1)) !== gtab[i]) begin failures++; $display("FAIL codes_reencode B=%b got=%b exp=%b", b, b ^ (b >> 1), gtab[i]); end
      $display("code G=%b B=%b lat=%0d", gtab[i], b, lat);
    end
  endtask

  task automatic test_hold_stall;
    G = 4'b1101; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    in_valid = 1'b1; G = 4'b0011;
    for (int c = 0; c < 5; c++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL hold_flags cyc=%0d out_valid=%b in_ready=%b busy=%b exp=1/0/1", c, out_valid, in_ready, busy); end
      checks++; if (B !== 4'b1001) begin failures++; $display("FAIL hold_B cyc=%0d got=%b exp=1001", c, B); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL hold_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
    checks++; if (B !== 4'b1001) begin failures++; $display("FAIL hold_B_after got=%b exp=1001", B); end
    $display("test_hold_stall G=1101 B=%b", B);
  endtask

  task automatic test_reset_mid;
    logic [3:0] b;
    int lat;
    int pulses = 0;
    G = 4'b1111; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL rstmid_flags in_ready=%b busy=%b out_valid=%b exp=1/0/0", in_ready, busy, out_valid); end
    checks++; if (B !== 4'b0000) begin failures++; $display("FAIL rstmid_B got=%b exp=0000", B); end
    for (int c = 0; c < 6; c++) begin
      if (out_valid) pulses++;
      tick();
    end
    checks++; if (pulses != 0) begin failures++; $display("FAIL rstmid_pulse got=%0d exp=0", pulses); end
    run_word(4'b0001, b, lat);
    checks++; if (b !== 4'b0001) begin failures++; $display("FAIL rstmid_next_B got=%b exp=0001", b); end
    $display("test_reset_mid next B=%b lat=%0d", b, lat);
  endtask

  task automatic test_back_to_back;
    logic [3:0] gseq [9] = '{4'b0110, 4'b1111, 4'b0000, 4'b1010, 4'b0101,
                             4'b1011, 4'b0010, 4'b1100, 4'b0111};
    out_ready = 1'b1;
    for (int k = 0; k < 9; k++) begin
      G = gseq[k]; in_valid = 1'b1;
      tick();
      if (k == 3) begin
        checks++; if (out_valid !== 1'b1 || B !== 4'b0100) begin failures++; $display("FAIL b2b_first out_valid=%b B=%b exp=1/0100", out_valid, B); end
      end
      if (k == 4) begin
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin failures++; $display("FAIL b2b_release in_ready=%b out_valid=%b exp=1/0", in_ready, out_valid); end
      end
      if (k == 5) begin
        checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL b2b_accept busy=%b in_ready=%b exp=1/0", busy, in_ready); end
      end
      if (k == 8) begin
        checks++; if (out_valid !== 1'b1 || B !== 4'b1101) begin failures++; $display("FAIL b2b_second out_valid=%b B=%b exp=1/1101", out_valid, B); end
      end
    end
    in_valid = 1'b0;
    tick();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_end in_ready=%b exp=1", in_ready); end
    $display("test_back_to_back second B=%b", B);
  endtask

  task automatic test_w8;
    int lat = 1;
    G8 = 8'b10000000; in_valid8 = 1'b1; out_ready8 = 1'b1;
    tick();
    in_valid8 = 1'b0; G8 = 8'h3c;
    while (!out_valid8 && lat < 30) begin
      tick();
      lat++;
    end
    checks++; if (lat != 8) begin failures++; $display("FAIL w8_latency got=%0d exp=8", lat); end
    checks++; if (B8 !== 8'hFF) begin failures++; $display("FAIL w8_B got=%h exp=ff", B8); end
    tick();
    checks++; if (in_ready8 !== 1'b1 || out_valid8 !== 1'b0) begin failures++; $display("FAIL w8_release in_ready=%b out_valid=%b exp=1/0", in_ready8, out_valid8); end
    $display("test_w8 G=10000000 B=%b lat=%0d", B8, lat);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_all_codes();
    test_hold_stall();
    test_reset_mid();
    test_back_to_back();
    test_w8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gray_2_binary_seq.md
GRAY_2_BINARY_SEQ -- requirements
Module: gray_2_binary_seq

Interface
REQ-001 The block SHALL have parameter W, default 4, meaning code width in bits, legal range 2..16.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 The block SHALL have port G, input, W bits: Gray-coded input word.
REQ-005 The block SHALL have port in_valid, input, 1 bit: G is valid this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts G this cycle.
REQ-007 The block SHALL have port B, output, W bits: decoded binary word.
REQ-008 The block SHALL have port out_valid, output, 1 bit: B holds a completed result.
REQ-009 The block SHALL have port out_ready, input, 1 bit: the consumer takes B this cycle.
REQ-010 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-011 The block SHALL implement FSM states IDLE, DECODE and HOLD.
REQ-012 in_ready SHALL be high only in IDLE; out_valid SHALL be high only in HOLD; both SHALL be registered state decodes.
REQ-013 A transfer in IDLE with in_valid=1 SHALL capture G into an internal register, set B[W-1]=G[W-1], clear B[W-2:0], load bit index idx=W-2, and go to DECODE.
REQ-014 On each DECODE edge the block SHALL set B[idx]=B[idx+1] XOR Greg[idx], decrement idx, and go to HOLD on the edge that resolves idx=0.
REQ-015 Decoding SHALL be bit-serial, MSB first, one bit per cycle; no combinational path SHALL exist from G to B.
REQ-016 Latency: counting the accepting edge as edge 1, out_valid SHALL rise after edge W (edge 4 for W=4).
REQ-017 In HOLD, B SHALL stay stable until a transfer with out_valid=1 and out_ready=1 occurs; the block SHALL then return to IDLE on that edge.
REQ-018 While out_ready=0, the block SHALL remain in HOLD indefinitely with in_ready=0, and no input SHALL be accepted.
REQ-019 in_valid SHALL be ignored outside IDLE, and G changes outside IDLE SHALL NOT affect the result.
REQ-020 Throughput SHALL be at most one word per W+1 cycles, since accept and release never occur on the same edge.
REQ-021 B SHALL retain its last completed value in IDLE until the next acceptance.
REQ-022 The index counter SHALL be ceil(log2(W)) bits wide and SHALL NOT wrap; DECODE exits before idx underflows.

Reset
REQ-023 While rst=1 at a rising edge, the block SHALL go to state IDLE and clear B, Greg and idx to 0; after reset, out_valid=0, busy=0 and in_ready=1.
REQ-024 rst SHALL take priority over every handshake, and reset in DECODE or HOLD SHALL discard the word in flight with no out_valid pulse.

Structure
REQ-025 Package gray_pkg SHALL hold the state enum type (IDLE, DECODE, HOLD) and the default width constant GRAY_W=4.
REQ-026 The block SHALL be a single module with no sub-modules; the per-bit XOR step is one line of logic and gets no separate module.

Verification
REQ-027 W=4, G=4'b0110 accepted with out_ready=1 -> out_valid rises after edge 4, B=4'b0100, then IDLE with in_ready=1.
REQ-028 W=4, all 16 Gray codes in sequence -> each B equals the inverse Gray of G (e.g. 4'b1000->4'b1111, 4'b0011->4'b0010), and every B re-encodes to its G.
REQ-029 W=4, G=4'b1101 with out_ready held 0 for 5 cycles in HOLD -> B=4'b1001 stable, out_valid=1 and in_ready=0 throughout; released on the first cycle out_ready=1.
REQ-030 W=4, rst asserted on the 2nd DECODE edge -> next cycle IDLE, B=0, out_valid=0; a following G=4'b0001 decodes to 4'b0001.
REQ-031 W=4, in_valid held 1 with G toggling every cycle -> only the word sampled on the IDLE edge is decoded, and the next word is accepted one cycle after release.
REQ-032 W=8, G=8'b10000000 -> out_valid rises after edge 8 with B=8'b11111111.
